fp32_add_arbiter: RTL

Shares one pipelined FP32 adder/subtracter (`fp32_adder_pipe`, fixed 4-cycle latency, no handshake of its own) among `NUM_REQ` requesters, such as FFT butterfly lanes. Each cycle the block grants one requester round-robin and drives its operands to the adder. It carries the requester ID down a tag pipeline matched to the adder latency, then returns the sum and flags to that requester as a one-cycle response pulse.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_rr_arbiter.sv | 53 +++++
 rtl/fp32_add_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP-unit definitions: rounding-mode and flag encodings, canonical NaN,
// and the tag carried alongside operations through fixed-latency pipes.
package fp_pkg;

    localparam logic [2:0]  FP_RM_DYN = 3'b111;
    localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;

    // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector
    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef struct packed {
        logic       vld;
        logic [2:0] id;
    } fp_tag_t;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer; the pointer moves to
// the requester after the winner whenever a grant is issued with advance set.
module fp_rr_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_any
);

    logic [IW-1:0] ptr_q, ptr_d;

    // Two passes: first the requesters at or above the pointer, then wrap.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!gnt_any && req[j] && (j >= 32'(ptr_q))) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_id  = IW'(j);
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_id  = IW'(j);
            end
        end
        ptr_d = ptr_q;
        if (advance && gnt_any) begin
            ptr_d = (32'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp32_add_arbiter.sv
// Round-robin sharing of one fixed-latency FP32 adder among NUM_REQ requesters.
// Optional sticky flag accumulator: define FP_ADD_ARB_FLAGS_ACC_EN.
module fp32_add_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADD_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_x,
    input  logic [32*NUM_REQ-1:0]  req_y,
    input  logic [NUM_REQ-1:0]     req_sub,
    input  logic [3*NUM_REQ-1:0]   req_rm,
    input  logic [2:0]             csr_frm,
    output logic [31:0]            add_x,
    output logic [31:0]            add_y,
    output logic                   add_sub,
    output logic [2:0]             add_rm,
    input  logic [31:0]            add_sum,
    input  logic [4:0]             add_flags,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_sum,
    output logic [4:0]             rsp_flags,
    output logic [3:0]             in_flight,
    output logic                   idle,
    output logic [4:0]             fflags_acc,
    input  logic                   fflags_clr
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_id;
    logic               gnt_any;

    fp_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (|req_valid),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign req_ready = gnt;

    // Operand mux: zero when nothing is granted; the tag marks that slot invalid.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
        add_rm  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                add_x   = req_x[32*i +: 32];
                add_y   = req_y[32*i +: 32];
                add_sub = req_sub[i];
                add_rm  = (req_rm[3*i +: 3] == FP_RM_DYN) ? csr_frm : req_rm[3*i +: 3];
            end
        end
    end

    fp_tag_t tag_q [ADD_LAT];
    fp_tag_t tag_d [ADD_LAT];
    fp_tag_t tag_out;
    logic    rsp_any;

    always_comb begin
        tag_d[0].vld = gnt_any;
        tag_d[0].id  = 3'(gnt_id);
        for (int unsigned k = 1; k < ADD_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '{default: '0};
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_out = tag_q[ADD_LAT-1];
    assign rsp_any = tag_out.vld;

    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = tag_out.vld && (tag_out.id == 3'(i));
        end
    end

    assign rsp_sum   = add_sum;
    assign rsp_flags = add_flags;

    logic [3:0] in_flight_q, in_flight_d;

    always_comb begin
        in_flight_d = in_flight_q;
        case ({gnt_any, rsp_any})
            2'b10:   in_flight_d = in_flight_q + 4'd1;
            2'b01:   in_flight_d = in_flight_q - 4'd1;
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_q <= '0;
        end else begin
            in_flight_q <= in_flight_d;
        end
    end

    assign in_flight = in_flight_q;
    assign idle      = (in_flight_q == '0) && !(|req_valid);

`ifdef FP_ADD_ARB_FLAGS_ACC_EN
    logic [4:0] fflags_q, fflags_d;

    // Clear first, so a coinciding response leaves only its own flags.
    always_comb begin
        fflags_d = fflags_clr ? '0 : fflags_q;
        if (rsp_any) begin
            fflags_d = fflags_d | add_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags_acc = fflags_q;
`else
    logic unused_fflags_clr;

    assign unused_fflags_clr = fflags_clr;
    assign fflags_acc        = '0;
`endif

endmodule
